// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debounce bank and its channels.
package debounce_pkg;

  localparam int STABLE_CYC_DEF = 100000;
  localparam int LONG_CYC_DEF   = 50000000;
  localparam int REPEAT_CYC_DEF = 10000000;

  localparam int STABLE_CYC_SIM = 8;
  localparam int LONG_CYC_SIM   = 40;
  localparam int REPEAT_CYC_SIM = 20;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } ch_evt_t;

  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_bank_if.sv
// Raw pin inputs and conditioned outputs of the debounce bank.
interface debounce_bank_if #(
  parameter int NUM_BTN = 4,
  parameter int NUM_SW  = 8
);

  logic [NUM_BTN-1:0] button;
  logic [NUM_SW-1:0]  SW;
  logic [NUM_BTN-1:0] button_out;
  logic [NUM_BTN-1:0] button_pulse;
  logic [NUM_BTN-1:0] button_release;
  logic [NUM_SW-1:0]  SW_OK;
  logic [NUM_SW-1:0]  sw_change;
  logic               rst_req;

  modport master (
    output button, SW,
    input  button_out, button_pulse, button_release, SW_OK, sw_change, rst_req
  );

  modport slave (
    input  button, SW,
    output button_out, button_pulse, button_release, SW_OK, sw_change, rst_req
  );

endinterface

// File: rtl/debounce_ch.sv
// One conditioned input: two-flop synchroniser, stability counter, held level
// with registered rise/fall pulses coincident with the level update.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int STABLE_CYC = STABLE_CYC_DEF
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    raw,
  output ch_evt_t evt
);

  localparam int             CW      = cnt_w(STABLE_CYC);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYC - 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      cnt  <= '0;
      evt  <= '0;
    end else begin
      meta     <= raw;
      sync     <= meta;
      evt.rise <= 1'b0;
      evt.fall <= 1'b0;
      if (sync == evt.level) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end else begin
        // sync has disagreed with the held level for STABLE_CYC samples in a row
        cnt       <= '0;
        evt.level <= sync;
        evt.rise  <= sync;
        evt.fall  <= ~sync;
      end
    end
  end

endmodule

// File: rtl/debounce_bank.sv
// Debounce bank: NUM_BTN buttons and NUM_SW switches with level/edge outputs and
// a long-press reset request. Define DEBOUNCE_AUTOREPEAT_EN for held-button auto-repeat.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int NUM_BTN    = 4,
  parameter int NUM_SW     = 8,
  parameter int STABLE_CYC = STABLE_CYC_DEF,
  parameter int LONG_CYC   = LONG_CYC_DEF,
  parameter int RST_IDX    = 0,
  parameter int REPEAT_CYC = REPEAT_CYC_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  debounce_bank_if.slave bus
);

  if (STABLE_CYC < 2 || LONG_CYC <= STABLE_CYC || RST_IDX < 0 || RST_IDX >= NUM_BTN ||
      REPEAT_CYC < 2) begin : g_param_err
    $error("debounce_bank: illegal parameter combination");
  end

  logic [NUM_BTN-1:0] btn_level, btn_rise, btn_fall;
  logic [NUM_SW-1:0]  sw_level, sw_rise, sw_fall;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    ch_evt_t evt;
    debounce_ch #(.STABLE_CYC(STABLE_CYC)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (bus.button[i]),
      .evt   (evt)
    );
    assign btn_level[i] = evt.level;
    assign btn_rise[i]  = evt.rise;
    assign btn_fall[i]  = evt.fall;
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    ch_evt_t evt;
    debounce_ch #(.STABLE_CYC(STABLE_CYC)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (bus.SW[i]),
      .evt   (evt)
    );
    assign sw_level[i] = evt.level;
    assign sw_rise[i]  = evt.rise;
    assign sw_fall[i]  = evt.fall;
  end

  localparam int HW = cnt_w(LONG_CYC + 1);

  logic [HW-1:0] hold_cnt;
  logic          rst_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      rst_q    <= 1'b0;
    end else begin
      if (!btn_level[RST_IDX]) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HW'(LONG_CYC)) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      rst_q <= btn_level[RST_IDX] && (hold_cnt >= HW'(LONG_CYC - 1));
    end
  end

  // Gating with the level drops rst_req on the same edge as button_release.
  assign bus.rst_req = rst_q & btn_level[RST_IDX];

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam int            RW      = cnt_w(REPEAT_CYC);
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYC - 1);

  logic [NUM_BTN-1:0] rep_hit;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_rep
    if (i == RST_IDX) begin : g_none
      assign rep_hit[i] = 1'b0;
    end else begin : g_cnt
      logic [RW-1:0] rep_cnt;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rep_cnt    <= '0;
          rep_hit[i] <= 1'b0;
        end else if (!btn_level[i]) begin
          rep_cnt    <= '0;
          rep_hit[i] <= 1'b0;
        end else begin
          rep_cnt    <= (rep_cnt == REP_MAX) ? '0 : rep_cnt + 1'b1;
          rep_hit[i] <= (rep_cnt == REP_MAX);
        end
      end
    end
  end

  // A repeat landing on the release edge is suppressed so press/release never overlap.
  assign bus.button_pulse = btn_rise | (rep_hit & btn_level);
`else
  assign bus.button_pulse = btn_rise;
`endif

  assign bus.button_out     = btn_level;
  assign bus.button_release = btn_fall;
  assign bus.SW_OK          = sw_level;
  assign bus.sw_change      = sw_rise | sw_fall;

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank: a window-based reference model predicts every
// cycle's outputs; a monitor pops and compares them one cycle at a time.
module tb_debounce_bank;
  import debounce_pkg::*;

  localparam int NB  = 4;
  localparam int NS  = 8;
  localparam int NCH = NB + NS;
  localparam int SC  = STABLE_CYC_SIM;
  localparam int LC  = LONG_CYC_SIM;
  localparam int RC  = REPEAT_CYC_SIM;

  logic clk;
  logic rst_n;

  debounce_bank_if #(.NUM_BTN(NB), .NUM_SW(NS)) bus ();

  debounce_bank #(
    .NUM_BTN    (NB),
    .NUM_SW     (NS),
    .STABLE_CYC (SC),
    .LONG_CYC   (LC),
    .RST_IDX    (0),
    .REPEAT_CYC (RC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int at_n, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s edge=%0d got=%h want=%h", nm, at_n, act, want);
    end
  endtask

  typedef struct {
    int             n;
    logic [NB-1:0]  bo, bp, br;
    logic [NS-1:0]  ok, ch;
    logic           rr;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: a level flips once the last SC synchronised samples
  // (raw delayed by two edges) all disagree with it.
  logic [NCH-1:0] hist[$];
  logic [NCH-1:0] win[$];
  logic [NCH-1:0] m_lvl = '0;
  int             t_rise[NCH];
  int             model_n = 0;

  task automatic model_edge(input logic [NB-1:0] b, input logic [NS-1:0] s, input logic r);
    exp_t           e;
    logic [NCH-1:0] raw, syn, flip;
    model_n++;
    e.n  = model_n;
    e.bo = '0; e.bp = '0; e.br = '0; e.ok = '0; e.ch = '0; e.rr = 1'b0;
    if (!r) begin
      hist.delete();
      win.delete();
      m_lvl = '0;
      exp_q.push_back(e);
      return;
    end
    raw = {s, b};
    hist.push_back(raw);
    if (hist.size() > 3) void'(hist.pop_front());
    syn = (hist.size() == 3) ? hist[0] : '0;
    win.push_back(syn);
    if (win.size() > SC) void'(win.pop_front());
    flip = '0;
    if (win.size() == SC) begin
      for (int c = 0; c < NCH; c++) begin
        logic all_diff;
        all_diff = 1'b1;
        foreach (win[k]) if (win[k][c] == m_lvl[c]) all_diff = 1'b0;
        flip[c] = all_diff;
      end
    end
    m_lvl = m_lvl ^ flip;
    for (int c = 0; c < NCH; c++) if (flip[c] && m_lvl[c]) t_rise[c] = model_n;
    e.bo = m_lvl[NB-1:0];
    e.bp = flip[NB-1:0] & m_lvl[NB-1:0];
    e.br = flip[NB-1:0] & ~m_lvl[NB-1:0];
    e.ok = m_lvl[NCH-1:NB];
    e.ch = flip[NCH-1:NB];
    e.rr = m_lvl[0] && ((model_n - t_rise[0]) >= LC);
`ifdef DEBOUNCE_AUTOREPEAT_EN
    for (int c = 1; c < NB; c++)
      if (m_lvl[c] && !flip[c] && ((model_n - t_rise[c]) % RC == 0)) e.bp[c] = 1'b1;
`endif
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [NB-1:0] b, input logic [NS-1:0] s, input logic r);
    @(negedge clk);
    bus.button = b;
    bus.SW     = s;
    rst_n      = r;
    model_edge(b, s, r);
  endtask

  // Event timestamps observed on the DUT, used for latency checks.
  int t_bo0_rise = -1, t_rr_rise = -1, t_rr_fall = -1, t_br0 = -1;
  int t_swc = -1, t_bo2_rise = -1, t_bpf = -1;
  int pulse_cnt[NB];
  logic prev_bo0 = 1'b0, prev_rr = 1'b0, prev_bo2 = 1'b0;

  initial for (int k = 0; k < NB; k++) pulse_cnt[k] = 0;

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("button_out",     e.n, 32'(bus.button_out),     32'(e.bo));
      chk("button_pulse",   e.n, 32'(bus.button_pulse),   32'(e.bp));
      chk("button_release", e.n, 32'(bus.button_release), 32'(e.br));
      chk("SW_OK",          e.n, 32'(bus.SW_OK),          32'(e.ok));
      chk("sw_change",      e.n, 32'(bus.sw_change),      32'(e.ch));
      chk("rst_req",        e.n, 32'(bus.rst_req),        32'(e.rr));
      if (bus.button_out[0] && !prev_bo0) t_bo0_rise = e.n;
      if (bus.button_out[2] && !prev_bo2) t_bo2_rise = e.n;
      if (bus.rst_req && !prev_rr) t_rr_rise = e.n;
      if (!bus.rst_req && prev_rr) t_rr_fall = e.n;
      if (bus.button_release[0]) t_br0 = e.n;
      if (bus.sw_change[3]) t_swc = e.n;
      if (bus.button_pulse == 4'hF) t_bpf = e.n;
      for (int k = 0; k < NB; k++) pulse_cnt[k] += int'(bus.button_pulse[k]);
      prev_bo0 = bus.button_out[0];
      prev_bo2 = bus.button_out[2];
      prev_rr  = bus.rst_req;
    end
  end

  initial begin
    int t_raw, n_rst, p_before;
    logic [NB-1:0] cur_b;
    logic [NS-1:0] cur_s;
    int rst_left;
    bus.button = '0;
    bus.SW     = '0;
    rst_n      = 1'b0;

    // Reset with all buttons held: one press pulse 10 cycles after release.
    repeat (3) step(4'hF, 8'h00, 1'b0);
    n_rst = model_n;
    repeat (13) step(4'hF, 8'h00, 1'b1);
    chk("press_after_reset_latency", model_n, 32'(t_bpf - n_rst), 32'd10);
    repeat (12) step(4'h0, 8'h00, 1'b1);

    // Glitch train on button[1]: never accepted.
    p_before = pulse_cnt[1];
    repeat (4) begin
      repeat (5) step(4'h2, 8'h00, 1'b1);
      repeat (3) step(4'h0, 8'h00, 1'b1);
    end
    repeat (12) step(4'h0, 8'h00, 1'b1);
    chk("glitch_no_pulse", model_n, 32'(pulse_cnt[1] - p_before), 32'd0);

    // Clean edges on SW[3].
    step(4'h0, 8'h08, 1'b1);
    t_raw = model_n - 1;
    repeat (14) step(4'h0, 8'h08, 1'b1);
    chk("sw_rise_latency", model_n, 32'(t_swc - t_raw), 32'd10);
    step(4'h0, 8'h00, 1'b1);
    t_raw = model_n - 1;
    repeat (14) step(4'h0, 8'h00, 1'b1);
    chk("sw_fall_latency", model_n, 32'(t_swc - t_raw), 32'd10);

    // Long press on button[0].
    repeat (70) step(4'h1, 8'h00, 1'b1);
    step(4'h0, 8'h00, 1'b1);
    t_raw = model_n - 1;
    repeat (14) step(4'h0, 8'h00, 1'b1);
    chk("rst_req_delay", model_n, 32'(t_rr_rise - t_bo0_rise), 32'(LC));
    chk("rst_req_fall_with_release", model_n, 32'(t_rr_fall), 32'(t_br0));
    chk("release_latency", model_n, 32'(t_br0 - t_raw), 32'd10);

    // Reset in the middle of a count on button[2].
    repeat (7) step(4'h4, 8'h00, 1'b1);
    step(4'h4, 8'h00, 1'b0);
    n_rst = model_n;
    repeat (14) step(4'h4, 8'h00, 1'b1);
    chk("count_discarded_latency", model_n, 32'(t_bo2_rise - n_rst), 32'd10);
    repeat (14) step(4'h0, 8'h00, 1'b1);

`ifdef DEBOUNCE_AUTOREPEAT_EN
    begin
      int p3, p0;
      p3 = pulse_cnt[3];
      p0 = pulse_cnt[0];
      repeat (80) step(4'h9, 8'h00, 1'b1);
      step(4'h0, 8'h00, 1'b1);
      repeat (14) step(4'h0, 8'h00, 1'b1);
      chk("repeat_btn3_count", model_n, 32'(pulse_cnt[3] - p3), 32'd4);
      chk("repeat_btn0_single", model_n, 32'(pulse_cnt[0] - p0), 32'd1);
    end
`endif

    // Randomised traffic with occasional resets.
    cur_b = '0;
    cur_s = '0;
    rst_left = 0;
    repeat (3000) begin
      for (int i = 0; i < NB; i++)
        if ($urandom_range(0, (i == 0) ? 40 : 10) == 0) cur_b[i] = ~cur_b[i];
      for (int i = 0; i < NS; i++)
        if ($urandom_range(0, 10) == 0) cur_s[i] = ~cur_s[i];
      if (rst_left > 0) rst_left--;
      else if ($urandom_range(0, 399) == 0) rst_left = $urandom_range(1, 3);
      step(cur_b, cur_s, (rst_left == 0));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", model_n, 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
